stack_master: RTL and testbench
===============================

Name: stack_master

Overview:
- Initiator for the 4-bit, 5-entry shared-bus stack: the block that issues NOP/PUSH/POP/GET commands on COMMAND/INDEX and drives or receives the bidirectional IO_DATA bus.
- Host logic sees a simple valid/ready request port and a one-cycle response strobe.
- The master tracks occupancy itself and rejects overflow, underflow and out-of-range GET before any bus cycle, so the stack never wraps and never overwrites data.

Parameters:
- DEPTH, 5: stack entries; must match the stack instance.
- DATA_W, 4: data width of IO_DATA, REQ_DATA and RSP_DATA.
- IDX_W, 3: width of INDEX; must satisfy 2**IDX_W >= DEPTH.

Ports:
- CLK  in  1  single clock; all state on rising edge except the read-capture register (falling edge).
- RESET  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  master can accept a request.
- REQ_CMD  in  2  NOP=00, PUSH=01, POP=10, GET=11.
- REQ_INDEX  in  IDX_W  GET depth below top; 0 = top.
- REQ_DATA  in  DATA_W  PUSH data.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_DATA  out  DATA_W  POP/GET result; 0 for NOP, PUSH and errors.
- RSP_ERR  out  1  request rejected; no bus cycle was issued.
- COUNT  out  $clog2(DEPTH+1)  current occupancy.
- COMMAND  out  2  stack command bus.
- INDEX  out  IDX_W  stack index bus.
- IO_DATA  inout  DATA_W  shared data bus.

Behaviour:
- Reset (RESET=0, async):
  - State = IDLE, COUNT=0.
  - COMMAND=NOP, INDEX=0, IO_DATA=Z.
  - REQ_READY=0 while reset is held; RSP_VALID=0, RSP_DATA=0, RSP_ERR=0.
  - Reset mid-operation aborts the transaction with no response and clears COUNT. The stack shares the same reset.
- State machine, states IDLE, ISSUE, RESP:
  - IDLE: REQ_READY=1. A handshake at edge t latches cmd, index and data.
    - Legal POP/GET/PUSH -> ISSUE.
    - NOP or illegal request -> RESP with the bus untouched.
  - ISSUE (cycle t+1): COMMAND/INDEX are registered outputs for exactly this cycle.
    - PUSH: IO_DATA = latched data for the whole cycle.
    - POP/GET: IO_DATA = Z; read data is captured on the falling edge of CLK in this cycle.
    - Next state RESP.
  - RESP: RSP_VALID=1 for one cycle.
    - Bus-command requests: response in cycle t+2.
    - NOP and errors: response in cycle t+1.
    - COMMAND returns to NOP. REQ_READY=0. Next state IDLE.
- Throughput: one request per 3 cycles (bus commands) or per 2 cycles (NOP/errors). There is no pipelining.
- Legality checks against COUNT at accept:
  - PUSH with COUNT==DEPTH -> ERR.
  - POP with COUNT==0 -> ERR.
  - GET with COUNT==0 or INDEX >= COUNT -> ERR.
  - Examples: INDEX=5..7 is always ERR; with COUNT=3, INDEX=3 is ERR and INDEX=2 is legal.
- COUNT update: increments on PUSH entering ISSUE, decrements on POP entering ISSUE. It never wraps and never leaves 0..DEPTH.
- Bus ownership:
  - The master drives IO_DATA only in the ISSUE cycle of a PUSH.
  - The master never drives IO_DATA while COMMAND is POP or GET.
  - No X or Z ever appears on COMMAND.
- RSP_DATA holds its value until the next RSP_VALID. RSP_ERR is meaningful only with RSP_VALID.

Decomposition:
- Package stack_pkg holds:
  - command encodings NOP, PUSH, POP, GET (2-bit);
  - STACK_DEPTH=5 and STACK_DATA_W=4;
  - the FSM state enum.
- One sub-module, stack_occupancy_tracker:
  - contains the COUNT register plus the full, empty and index-in-range comparators;
  - its inputs are inc, dec, req_cmd and req_index; its outputs are count and legal.

Test Plan:
- Reset released, then PUSH 4'hA, 4'h5, 4'h3 -> each RSP_VALID two cycles after accept, RSP_ERR=0; COUNT=3; COMMAND=01 for one cycle per push with IO_DATA=A/5/3.
- From that state, GET INDEX=0, 1, 2 -> RSP_DATA=3, 5, A; COUNT stays 3; IO_DATA never driven by the master.
- POP three times -> RSP_DATA=3, 5, A; COUNT 2, 1, 0; a fourth POP -> RSP_ERR=1 one cycle after accept, COMMAND stays 00.
- Push 5 values 1..5, then PUSH 4'hF -> RSP_ERR=1, COUNT=5; GET INDEX=4 -> RSP_DATA=1; GET INDEX=5 -> RSP_ERR=1.
- NOP request -> RSP_VALID next cycle, RSP_DATA=0, RSP_ERR=0, no bus activity; holding REQ_VALID continuously -> REQ_READY=0 in ISSUE/RESP and no request is lost or duplicated.
- Assert RESET during the ISSUE cycle of a PUSH -> IO_DATA=Z and COMMAND=00 immediately, no RSP_VALID, COUNT=0 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared command encodings, stack geometry and master FSM states
package stack_pkg;
    localparam int STACK_DEPTH  = 5;
    localparam int STACK_DATA_W = 4;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/stack_occupancy_tracker.sv
// rtl/stack_occupancy_tracker.sv - occupancy counter and request legality against it
module stack_occupancy_tracker
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int IDX_W = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    input  logic [1:0]                   req_cmd,
    input  logic [IDX_W-1:0]             req_index,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         legal
);
    localparam int CW = $clog2(DEPTH + 1);

    logic full;
    logic empty;
    logic in_range;

    assign full     = (int'(count) == DEPTH);
    assign empty    = (count == '0);
    assign in_range = (int'(req_index) < int'(count));

    always_comb begin
        legal = 1'b1;
        case (req_cmd)
            CMD_PUSH: legal = !full;
            CMD_POP:  legal = !empty;
            CMD_GET:  legal = in_range;
            default:  legal = 1'b1;
        endcase
    end

    // Guarded again here so the counter cannot leave 0..DEPTH whatever the caller does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + CW'(1);
        end else if (dec && !empty) begin
            count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/stack_master.sv
// rtl/stack_master.sv - host request port to shared-bus stack command initiator
module stack_master
    import stack_pkg::*;
#(
    parameter int DEPTH  = STACK_DEPTH,
    parameter int DATA_W = STACK_DATA_W,
    parameter int IDX_W  = 3
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        REQ_VALID,
    output logic                        REQ_READY,
    input  logic [1:0]                  REQ_CMD,
    input  logic [IDX_W-1:0]            REQ_INDEX,
    input  logic [DATA_W-1:0]           REQ_DATA,
    output logic                        RSP_VALID,
    output logic [DATA_W-1:0]           RSP_DATA,
    output logic                        RSP_ERR,
    output logic [$clog2(DEPTH+1)-1:0]  COUNT,
    output logic [1:0]                  COMMAND,
    output logic [IDX_W-1:0]            INDEX,
    inout  wire  [DATA_W-1:0]           IO_DATA
);
    state_t              state, state_d;
    logic [1:0]          command_d;
    logic [IDX_W-1:0]    index_d;
    logic                drive_q, drive_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   cap_q;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;
    logic                legal;
    logic                accept;
    logic                is_bus;

    assign accept    = (state == ST_IDLE) && REQ_VALID;
    assign is_bus    = (REQ_CMD != CMD_NOP) && legal;
    assign REQ_READY = (state == ST_IDLE) && RESET;
    assign RSP_VALID = (state == ST_RESP);
    assign IO_DATA   = drive_q ? data_q : {DATA_W{1'bz}};

    stack_occupancy_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tracker (
        .clk       (CLK),
        .rst_n     (RESET),
        .inc       (accept && is_bus && (REQ_CMD == CMD_PUSH)),
        .dec       (accept && is_bus && (REQ_CMD == CMD_POP)),
        .req_cmd   (REQ_CMD),
        .req_index (REQ_INDEX),
        .count     (COUNT),
        .legal     (legal)
    );

    always_comb begin
        state_d    = state;
        command_d  = CMD_NOP;
        index_d    = '0;
        drive_d    = 1'b0;
        rsp_data_d = RSP_DATA;
        rsp_err_d  = RSP_ERR;
        case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (is_bus) begin
                        state_d   = ST_ISSUE;
                        command_d = REQ_CMD;
                        index_d   = (REQ_CMD == CMD_GET) ? REQ_INDEX : '0;
                        drive_d   = (REQ_CMD == CMD_PUSH);
                    end else begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = (REQ_CMD != CMD_NOP);
                    end
                end
            end
            ST_ISSUE: begin
                state_d    = ST_RESP;
                rsp_data_d = (COMMAND == CMD_PUSH) ? '0 : cap_q;
                rsp_err_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            COMMAND  <= CMD_NOP;
            INDEX    <= '0;
            drive_q  <= 1'b0;
            data_q   <= '0;
            RSP_DATA <= '0;
            RSP_ERR  <= 1'b0;
        end else begin
            state    <= state_d;
            COMMAND  <= command_d;
            INDEX    <= index_d;
            drive_q  <= drive_d;
            RSP_DATA <= rsp_data_d;
            RSP_ERR  <= rsp_err_d;
            if (accept) begin
                data_q <= REQ_DATA;
            end
        end
    end

    // The stack drives read data during the ISSUE cycle; sample mid-cycle once it has settled.
    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            cap_q <= '0;
        end else if (state == ST_ISSUE && (COMMAND == CMD_POP || COMMAND == CMD_GET)) begin
            cap_q <= IO_DATA;
        end
    end
endmodule

// File: tb/tb_stack_master.sv
// tb/tb_stack_master.sv - directed self-checking bench with a behavioural stack on the bus
module tb_stack_master;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_CMD = 2'b00;
    logic [2:0] REQ_INDEX = 3'd0;
    logic [3:0] REQ_DATA = 4'd0;
    logic       RSP_VALID;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [2:0] COUNT;
    logic [1:0] COMMAND;
    logic [2:0] INDEX;
    wire  [3:0] IO_DATA;

    int checks = 0;
    int errors = 0;

    stack_master dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_CMD   (REQ_CMD),
        .REQ_INDEX (REQ_INDEX),
        .REQ_DATA  (REQ_DATA),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .COUNT     (COUNT),
        .COMMAND   (COMMAND),
        .INDEX     (INDEX),
        .IO_DATA   (IO_DATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural stack target sharing the bus and reset
    logic [3:0] mem [0:4];
    logic [2:0] sp;
    logic [3:0] model_rd;
    int         rd_ptr;

    always_comb begin
        rd_ptr   = int'(sp) - 1 - ((COMMAND == 2'b11) ? int'(INDEX) : 0);
        model_rd = (rd_ptr >= 0 && rd_ptr < 5) ? mem[rd_ptr] : 4'd0;
    end

    assign IO_DATA = (COMMAND == 2'b10 || COMMAND == 2'b11) ? model_rd : 4'bzzzz;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sp <= 3'd0;
        end else begin
            case (COMMAND)
                2'b01: if (sp < 3'd5) begin mem[sp] <= IO_DATA; sp <= sp + 3'd1; end
                2'b10: if (sp > 3'd0) sp <= sp - 3'd1;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One request; bus=1 expects an ISSUE cycle before the response
    task automatic req(input string tag, input logic [1:0] c, input logic [2:0] i,
                       input logic [3:0] d, input bit bus, input bit e, input logic [3:0] rd);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_CMD = c; REQ_INDEX = i; REQ_DATA = d;
        chk({tag, ".ready"}, 8'(REQ_READY), 8'd1);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        if (bus) begin
            chk({tag, ".cmd"}, 8'(COMMAND), 8'(c));
            chk({tag, ".early_rsp"}, 8'(RSP_VALID), 8'd0);
            chk({tag, ".ready_issue"}, 8'(REQ_READY), 8'd0);
            if (c == 2'b01) chk({tag, ".io_push"}, 8'(IO_DATA), 8'(d));
            else chk({tag, ".io_read"}, 8'(IO_DATA), 8'(rd));
            if (c == 2'b11) chk({tag, ".index"}, 8'(INDEX), 8'(i));
            @(negedge CLK);
        end
        chk({tag, ".rsp_valid"}, 8'(RSP_VALID), 8'd1);
        chk({tag, ".rsp_err"}, 8'(RSP_ERR), 8'(e));
        chk({tag, ".rsp_data"}, 8'(RSP_DATA), 8'(rd));
        chk({tag, ".cmd_resp"}, 8'(COMMAND), 8'd0);
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst.ready", 8'(REQ_READY), 8'd0);
        chk("rst.rsp_valid", 8'(RSP_VALID), 8'd0);
        chk("rst.rsp_data", 8'(RSP_DATA), 8'd0);
        chk("rst.rsp_err", 8'(RSP_ERR), 8'd0);
        chk("rst.count", 8'(COUNT), 8'd0);
        chk("rst.cmd", 8'(COMMAND), 8'd0);
        chk("rst.index", 8'(INDEX), 8'd0);
        RESET = 1'b1;

        req("push_a", 2'b01, 3'd0, 4'hA, 1, 0, 4'h0);
        req("push_5", 2'b01, 3'd0, 4'h5, 1, 0, 4'h0);
        req("push_3", 2'b01, 3'd0, 4'h3, 1, 0, 4'h0);
        chk("count3", 8'(COUNT), 8'd3);

        req("get0", 2'b11, 3'd0, 4'h0, 1, 0, 4'h3);
        req("get1", 2'b11, 3'd1, 4'h0, 1, 0, 4'h5);
        req("get2", 2'b11, 3'd2, 4'h0, 1, 0, 4'hA);
        chk("count_get", 8'(COUNT), 8'd3);
        req("get3_err", 2'b11, 3'd3, 4'h0, 0, 1, 4'h0);

        req("pop1", 2'b10, 3'd0, 4'h0, 1, 0, 4'h3);
        chk("count_pop1", 8'(COUNT), 8'd2);
        req("pop2", 2'b10, 3'd0, 4'h0, 1, 0, 4'h5);
        chk("count_pop2", 8'(COUNT), 8'd1);
        req("pop3", 2'b10, 3'd0, 4'h0, 1, 0, 4'hA);
        chk("count_pop3", 8'(COUNT), 8'd0);
        req("pop_under", 2'b10, 3'd0, 4'h0, 0, 1, 4'h0);
        chk("count_under", 8'(COUNT), 8'd0);
        req("get_empty", 2'b11, 3'd0, 4'h0, 0, 1, 4'h0);

        for (int v = 1; v <= 5; v++) req("fill", 2'b01, 3'd0, 4'(v), 1, 0, 4'h0);
        req("push_over", 2'b01, 3'd0, 4'hF, 0, 1, 4'h0);
        chk("count_full", 8'(COUNT), 8'd5);
        req("get4", 2'b11, 3'd4, 4'h0, 1, 0, 4'h1);
        req("get5_err", 2'b11, 3'd5, 4'h0, 0, 1, 4'h0);
        req("get7_err", 2'b11, 3'd7, 4'h0, 0, 1, 4'h0);
        req("nop", 2'b00, 3'd0, 4'h9, 0, 0, 4'h0);
        chk("count_nop", 8'(COUNT), 8'd5);

        // REQ_VALID held high: two POPs accepted over six cycles
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_CMD = 2'b10; REQ_INDEX = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge CLK);
            chk("hold.ready", 8'(REQ_READY), (k % 3 == 0) ? 8'd1 : 8'd0);
            chk("hold.rsp", 8'(RSP_VALID), (k % 3 == 2) ? 8'd1 : 8'd0);
        end
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("hold.count", 8'(COUNT), 8'd3);
        req("hold.get0", 2'b11, 3'd0, 4'h0, 1, 0, 4'h3);

        // Reset asserted in the ISSUE cycle of a PUSH
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_CMD = 2'b01; REQ_DATA = 4'h9;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        chk("rstmid.cmd_issue", 8'(COMMAND), 8'd1);
        #2 RESET = 1'b0;
        #1;
        chk("rstmid.cmd", 8'(COMMAND), 8'd0);
        chk("rstmid.rsp", 8'(RSP_VALID), 8'd0);
        chk("rstmid.count", 8'(COUNT), 8'd0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("rstmid.no_rsp", 8'(RSP_VALID), 8'd0);
        end
        chk("rstmid.count_after", 8'(COUNT), 8'd0);
        req("rstmid.pop_err", 2'b10, 3'd0, 4'h0, 0, 1, 4'h0);
        req("rstmid.push7", 2'b01, 3'd0, 4'h7, 1, 0, 4'h0);
        req("rstmid.pop7", 2'b10, 3'd0, 4'h0, 1, 0, 4'h7);
        chk("final.count", 8'(COUNT), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
